// File: rtl/core_wb_arb.sv
// Write-back arbiter for the GPR file's single write port, plus a scoreboard
// of destination registers with results still in flight.
module core_wb_arb #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4,
    parameter int NREGS  = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alu_valid,
    input  logic [ADDR_W-1:0] alu_addr,
    input  logic [DATA_W-1:0] alu_data,
    output logic              alu_ready,
    input  logic              lsu_valid,
    input  logic [ADDR_W-1:0] lsu_addr,
    input  logic [DATA_W-1:0] lsu_data,
    output logic              lsu_ready,
    input  logic              mul_valid,
    input  logic [ADDR_W-1:0] mul_addr,
    input  logic [DATA_W-1:0] mul_data,
    output logic              mul_ready,
    output logic              wb,
    output logic [ADDR_W-1:0] wb_addr,
    output logic [DATA_W-1:0] wb_data,
    input  logic              sb_set,
    input  logic [ADDR_W-1:0] sb_addr,
    input  logic [ADDR_W-1:0] rega_addr,
    input  logic [ADDR_W-1:0] regb_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    output logic              rega_busy,
    output logic              regb_busy,
    output logic              dst_busy
);

    localparam int NBUSY = 1 << ADDR_W;

    logic [1:0]        rr_q, rr_d;
    logic              wb_q, wb_d;
    logic [ADDR_W-1:0] wb_addr_q, wb_addr_d;
    logic [DATA_W-1:0] wb_data_q, wb_data_d;
    logic [NBUSY-1:0]  busy_q, busy_d;

    logic [3:0]        valid;
    logic [3:0]        grant;
    logic [2:0]        pos;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return int'(a) < NREGS;
    endfunction

    // Search rr, rr+1, rr+2 (mod 3); valid/grant carry a spare bit so the
    // 2-bit search index never selects outside the vector.
    always_comb begin
        valid = {1'b0, mul_valid, lsu_valid, alu_valid};
        grant = '0;
        pos   = '0;
        for (int unsigned k = 0; k < 3; k++) begin
            pos = {1'b0, rr_q} + 3'(k);
            if (pos >= 3'd3) pos = pos - 3'd3;
            if (grant == '0 && valid[pos[1:0]]) grant[pos[1:0]] = 1'b1;
        end
        if (rst) grant = '0;
    end

    always_comb begin
        sel_addr = mul_addr;
        sel_data = mul_data;
        rr_d     = rr_q;
        if (grant[0]) begin
            sel_addr = alu_addr;
            sel_data = alu_data;
            rr_d     = 2'd1;
        end else if (grant[1]) begin
            sel_addr = lsu_addr;
            sel_data = lsu_data;
            rr_d     = 2'd2;
        end else if (grant[2]) begin
            rr_d     = 2'd0;
        end
    end

    // Out-of-range results are consumed silently and leave the port idle.
    always_comb begin
        wb_d      = (grant != '0) && in_range(sel_addr);
        wb_addr_d = wb_d ? sel_addr : wb_addr_q;
        wb_data_d = wb_d ? sel_data : wb_data_q;
    end

    // Set is applied after clear so a same-cycle set on the written register wins.
    always_comb begin
        busy_d = busy_q;
        if (wb_q) busy_d[wb_addr_q] = 1'b0;
        if (sb_set && in_range(sb_addr)) busy_d[sb_addr] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_q      <= '0;
            wb_q      <= 1'b0;
            wb_addr_q <= '0;
            wb_data_q <= '0;
            busy_q    <= '0;
        end else begin
            rr_q      <= rr_d;
            wb_q      <= wb_d;
            wb_addr_q <= wb_addr_d;
            wb_data_q <= wb_data_d;
            busy_q    <= busy_d;
        end
    end

    assign alu_ready = grant[0];
    assign lsu_ready = grant[1];
    assign mul_ready = grant[2];
    assign wb        = wb_q;
    assign wb_addr   = wb_addr_q;
    assign wb_data   = wb_data_q;
    assign rega_busy = busy_q[rega_addr];
    assign regb_busy = busy_q[regb_addr];
    assign dst_busy  = busy_q[dst_addr];

endmodule
